multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control unit that issues operations to the 4-bit-opcode ALU. It accepts one RV32I instruction word per transaction and decodes it. It sequences that instruction through DECODE, EXEC, MEM and WB, driving the ALU opcode, operand select, immediate, register-file, memory and PC controls. It samples the ALU `zero`/`carry` flags to resolve BEQ/BNE.

## Interface
Parameters:
- `XLEN`, 32, datapath/immediate width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `instr`  in  32  instruction word; sampled on accept.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  high only in IDLE.
- `alu_op`  out  4  ALU opcode.
- `alu_src_imm`  out  1  1 selects `imm` as ALU B; 0 selects rs2.
- `imm`  out  32  decoded immediate.
- `rs1`, `rs2`, `rd`  out  5 each  register addresses.
- `alu_zero`, `alu_carry`  in  1 each  ALU flags.
- `reg_we`  out  1  register-file write strobe.
- `mem_re`, `mem_we`  out  1 each  data-memory strobes.
- `pc_we`  out  1  PC update strobe.
- `pc_sel`  out  1  1 = branch target, 0 = PC+4.
- `done`  out  1  one-cycle pulse at end of instruction.
- `illegal`  out  1  one-cycle pulse for an undecodable instruction.

## Operation
- States: IDLE, DECODE, EXEC, MEM, WB. Moore outputs are derived from the state and the registered instruction fields.
- IDLE: when `instr_valid && instr_ready`, latch `instr` and go to DECODE.
- DECODE: classify the instruction and register `alu_op`, `imm`, the register fields and `alu_src_imm`. Go to EXEC, or handle illegal (see Configuration).
- EXEC: drive `alu_op` and operands. Register the branch decision at the end of this cycle:
  - BEQ taken when `alu_carry == 1`.
  - BNE taken when `alu_zero == 1`.
  - Next state: MEM for LW/SW, else WB.
- MEM: `mem_re` for LW, `mem_we` for SW; then WB.
- WB: `pc_we = 1` and `done = 1`.
  - `pc_sel` = registered taken flag for branches, 0 otherwise.
  - `reg_we = 1` for R-type, I-ALU, LW, LUI.
  - Then IDLE.
- Opcode map: ADD 0, SUB 1, SLL 2, XOR 3, SRL 4, SRA 5, OR 6, AND 7, SLTU 8, BNE 9, BEQ A, LUI B.
- R-type (0110011): funct3 selects the op. funct7[5] selects SUB for funct3 000 and SRA for funct3 101.
- I-ALU (0010011): ADDI, XORI, ORI, ANDI and SLTIU use sign-extended `instr[31:20]`. SLLI, SRLI and SRAI use zero-extended `instr[24:20]`, with `instr[30]` selecting SRAI.
- LW/SW: ADD with sign-extended I/S immediate.
- Branches: `alu_src_imm = 0`. `imm` carries the sign-extended B immediate for the PC adder.
- LUI: opcode B, `imm = {12'b0, instr[31:12]}`, because the ALU shifts B left by 12.
- Unsupported opcodes and funct3 values are illegal.

## Timing
- Accept at edge T. The instruction then completes with `done` high in the following cycle:
  - R/I/LUI/branch: cycle T+3.
  - LW/SW: cycle T+4.
- `instr_ready` is low from DECODE through WB. `instr_valid` seen outside IDLE is ignored.
- `done`, `illegal`, `pc_we` and `reg_we` are exactly one cycle wide.
- Reset values: while `rst_n` is low, every output is 0 and the state goes to IDLE at the edge. The first cycle after release has `instr_ready = 1`.
- Reset mid-instruction abandons it with no strobe issued. `pc_we` and `reg_we` must not fire in the cycle following reset release.
- Back-to-back: a new instruction can be accepted in the cycle after WB.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal instruction pulses `illegal` in the cycle after DECODE and returns to IDLE.
  - No `pc_we`, `reg_we`, `mem_*` or `done` is issued.
- `CTRL_ILLEGAL_TRAP_EN` undefined:
  - An illegal instruction is a NOP: DECODE → EXEC (`alu_op = 0`) → WB.
  - WB has `pc_we = 1`, `pc_sel = 0`, `reg_we = 0` and `done = 1`; `illegal` stays 0.

## Test plan
- `0x002081B3` (ADD x3,x1,x2) → in EXEC: `alu_op = 0`, `alu_src_imm = 0`, `rs1 = 1`, `rs2 = 2`. In WB (T+3): `rd = 3`, `reg_we = 1`, `done = 1`.
- `0x402081B3` (SUB) → `alu_op = 1`. `0x4020D1B3` (SRA) → `alu_op = 5`.
- `0x0080A283` (LW x5,8(x1)) → `alu_op = 0`, `imm = 8`, `mem_re` at T+3, `reg_we` and `done` at T+4.
- `0x00208463` (BEQ x1,x2,+8) → `alu_op = A`, `imm = 8`:
  - with `alu_carry = 1` in EXEC: `pc_sel = 1` in WB.
  - with `alu_carry = 0`: `pc_sel = 0`.
- `0x123453B7` (LUI x7) → `alu_op = B`, `imm = 0x00012345`, `reg_we = 1`, `rd = 7`.
- `0xFFFFFFFF` → with the macro: `illegal` pulse and no `done`. Without it: `done = 1`, `reg_we = 0`.
- Also: `rst_n` low during EXEC → outputs 0 and no WB strobes; the next instruction is accepted normally.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control unit: IDLE -> DECODE -> EXEC -> (MEM) -> WB.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal instructions instead of retiring them as NOPs.
module multicycle_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [3:0]      alu_op,
    output logic            alu_src_imm,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    input  logic            alu_zero,
    input  logic            alu_carry,
    output logic            reg_we,
    output logic            mem_re,
    output logic            mem_we,
    output logic            pc_we,
    output logic            pc_sel,
    output logic            done,
    output logic            illegal
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [2:0] K_R    = 3'd0;
    localparam logic [2:0] K_IALU = 3'd1;
    localparam logic [2:0] K_LW   = 3'd2;
    localparam logic [2:0] K_SW   = 3'd3;
    localparam logic [2:0] K_BEQ  = 3'd4;
    localparam logic [2:0] K_BNE  = 3'd5;
    localparam logic [2:0] K_LUI  = 3'd6;
    localparam logic [2:0] K_ILL  = 3'd7;

    logic [2:0]      state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [2:0]      kind_q, kind_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [4:0]      rd_q, rd_d;
    logic            src_imm_q, src_imm_d;
    logic            taken_q, taken_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic            illegal_q, illegal_d;
`endif

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i, imm_sh, imm_s, imm_b, imm_u;
    logic [2:0]      dec_kind;
    logic [3:0]      dec_op;
    logic [XLEN-1:0] dec_imm;
    logic            dec_src;

    assign opc    = instr_q[6:0];
    assign f3     = instr_q[14:12];
    assign imm_i  = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
    assign imm_sh = {{(XLEN-5){1'b0}}, instr_q[24:20]};
    assign imm_s  = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b  = {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7],
                     instr_q[30:25], instr_q[11:8], 1'b0};
    // LUI immediate is left unshifted; the ALU applies the 12-bit shift itself.
    assign imm_u  = {{(XLEN-20){1'b0}}, instr_q[31:12]};

    always_comb begin
        dec_kind = K_ILL;
        dec_op   = 4'h0;
        dec_imm  = '0;
        dec_src  = 1'b0;
        case (opc)
            7'b0110011: begin
                dec_kind = K_R;
                case (f3)
                    3'b000:  dec_op = instr_q[30] ? 4'h1 : 4'h0;
                    3'b001:  dec_op = 4'h2;
                    3'b011:  dec_op = 4'h8;
                    3'b100:  dec_op = 4'h3;
                    3'b101:  dec_op = instr_q[30] ? 4'h5 : 4'h4;
                    3'b110:  dec_op = 4'h6;
                    3'b111:  dec_op = 4'h7;
                    default: dec_kind = K_ILL;
                endcase
            end
            7'b0010011: begin
                dec_kind = K_IALU;
                dec_src  = 1'b1;
                dec_imm  = imm_i;
                case (f3)
                    3'b000:  dec_op = 4'h0;
                    3'b001: begin
                        dec_op  = 4'h2;
                        dec_imm = imm_sh;
                    end
                    3'b011:  dec_op = 4'h8;
                    3'b100:  dec_op = 4'h3;
                    3'b101: begin
                        dec_op  = instr_q[30] ? 4'h5 : 4'h4;
                        dec_imm = imm_sh;
                    end
                    3'b110:  dec_op = 4'h6;
                    3'b111:  dec_op = 4'h7;
                    default: dec_kind = K_ILL;
                endcase
            end
            7'b0000011: begin
                if (f3 == 3'b010) begin
                    dec_kind = K_LW;
                    dec_src  = 1'b1;
                    dec_imm  = imm_i;
                end
            end
            7'b0100011: begin
                if (f3 == 3'b010) begin
                    dec_kind = K_SW;
                    dec_src  = 1'b1;
                    dec_imm  = imm_s;
                end
            end
            7'b1100011: begin
                dec_imm = imm_b;
                if (f3 == 3'b000) begin
                    dec_kind = K_BEQ;
                    dec_op   = 4'hA;
                end else if (f3 == 3'b001) begin
                    dec_kind = K_BNE;
                    dec_op   = 4'h9;
                end
            end
            7'b0110111: begin
                dec_kind = K_LUI;
                dec_op   = 4'hB;
                dec_src  = 1'b1;
                dec_imm  = imm_u;
            end
            default: dec_kind = K_ILL;
        endcase
        // An undecodable word must present a clean ADD with no operands selected.
        if (dec_kind == K_ILL) begin
            dec_op  = 4'h0;
            dec_imm = '0;
            dec_src = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        kind_d    = kind_q;
        alu_op_d  = alu_op_q;
        imm_d     = imm_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        src_imm_d = src_imm_q;
        taken_d   = taken_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (instr_valid && instr_ready) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                kind_d    = dec_kind;
                alu_op_d  = dec_op;
                imm_d     = dec_imm;
                src_imm_d = dec_src;
                rs1_d     = instr_q[19:15];
                rs2_d     = instr_q[24:20];
                rd_d      = instr_q[11:7];
                taken_d   = 1'b0;
                state_d   = S_EXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (dec_kind == K_ILL) begin
                    illegal_d = 1'b1;
                    state_d   = S_IDLE;
                end
`endif
            end
            S_EXEC: begin
                taken_d = ((kind_q == K_BEQ) && alu_carry) ||
                          ((kind_q == K_BNE) && alu_zero);
                state_d = ((kind_q == K_LW) || (kind_q == K_SW)) ? S_MEM : S_WB;
            end
            S_MEM:   state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            kind_q    <= K_ILL;
            alu_op_q  <= '0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            src_imm_q <= 1'b0;
            taken_q   <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            kind_q    <= kind_d;
            alu_op_q  <= alu_op_d;
            imm_q     <= imm_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            src_imm_q <= src_imm_d;
            taken_q   <= taken_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Outputs are forced low for the whole time reset is held, not just after the edge.
    assign instr_ready = rst_n && (state_q == S_IDLE);
    assign alu_op      = rst_n ? alu_op_q : 4'h0;
    assign alu_src_imm = rst_n && src_imm_q;
    assign imm         = rst_n ? imm_q : '0;
    assign rs1         = rst_n ? rs1_q : 5'd0;
    assign rs2         = rst_n ? rs2_q : 5'd0;
    assign rd          = rst_n ? rd_q : 5'd0;
    assign mem_re      = rst_n && (state_q == S_MEM) && (kind_q == K_LW);
    assign mem_we      = rst_n && (state_q == S_MEM) && (kind_q == K_SW);
    assign pc_we       = rst_n && (state_q == S_WB);
    assign done        = rst_n && (state_q == S_WB);
    assign pc_sel      = rst_n && (state_q == S_WB) && taken_q &&
                         ((kind_q == K_BEQ) || (kind_q == K_BNE));
    assign reg_we      = rst_n && (state_q == S_WB) &&
                         ((kind_q == K_R) || (kind_q == K_IALU) ||
                          (kind_q == K_LW) || (kind_q == K_LUI));
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal     = rst_n && illegal_q;
`else
    assign illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven, scoreboarded bench for multicycle_ctrl; illegal-instruction
// expectations follow CTRL_ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl;

    localparam int M_OP  = 1;
    localparam int M_IMM = 2;
    localparam int M_SRC = 4;
    localparam int M_RS1 = 8;
    localparam int M_RS2 = 16;
    localparam int M_RD  = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        alu_zero, alu_carry;
    logic        reg_we, mem_re, mem_we, pc_we, pc_sel, done, illegal;

    typedef struct {
        logic [31:0] instr;
        logic        carry;
        logic        zero;
        logic [3:0]  op;
        logic [31:0] imm;
        logic        src;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        int          mask;
        int          len;
        logic        rwe;
        logic        psel;
        logic        ill;
        int          mre;
        int          mwe;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .done(done), .illegal(illegal)
    );

    function automatic logic [63:0] allOuts();
        return {4'b0, instr_ready, alu_op, alu_src_imm, imm, rs1, rs2, rd,
                reg_we, mem_re, mem_we, pc_we, pc_sel, done, illegal};
    endfunction

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic c, input logic z,
                                input logic [3:0] op, input logic [31:0] im, input logic src,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                                input int mask, input int len, input logic rwe, input logic psel,
                                input int mre, input int mwe);
        vec_t v;
        v.instr = i; v.carry = c; v.zero = z; v.op = op; v.imm = im; v.src = src;
        v.rs1 = r1; v.rs2 = r2; v.rd = d; v.mask = mask; v.len = len;
        v.rwe = rwe; v.psel = psel; v.ill = 1'b0; v.mre = mre; v.mwe = mwe;
        return v;
    endfunction

    function automatic vec_t mkIllegal(input logic [31:0] i);
        vec_t v;
`ifdef CTRL_ILLEGAL_TRAP_EN
        v = mk(i, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        v.ill = 1'b1;
`else
        v = mk(i, 0, 0, 4'h0, 0, 0, 0, 0, 0, M_OP, 3, 0, 0, 0, 0);
`endif
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        instr       = v.instr;
        instr_valid = 1'b1;
        alu_carry   = ~v.carry;
        alu_zero    = ~v.zero;
        #1;
        compare("ready_in_idle", instr_ready, 1);
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input int cyc, input int mre_seen, input int mwe_seen);
        vec_t e;
        compare("scoreboard_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare("latency", cyc, e.len);
            compare("done", done, !e.ill);
            compare("illegal", illegal, e.ill);
            compare("pc_we", pc_we, !e.ill);
            compare("reg_we", reg_we, e.rwe);
            compare("pc_sel", pc_sel, e.psel);
            compare("mem_re_cycle", mre_seen, e.mre);
            compare("mem_we_cycle", mwe_seen, e.mwe);
            if ((e.mask & M_RD) != 0) compare("rd", rd, e.rd);
        end
        @(negedge clk);
        compare("post_pulses", {done, illegal, pc_we, reg_we, mem_re, mem_we}, 6'b0);
        compare("post_ready", instr_ready, 1);
    endtask

    task automatic runVector(input vec_t v);
        int mre_seen = 0;
        int mwe_seen = 0;
        bit ended = 1'b0;
        applyStimulus(v);
        for (int c = 1; c <= 8 && !ended; c++) begin
            @(negedge clk);
            if (c == 1) begin
                instr = ~v.instr;
                compare("ready_busy", instr_ready, 0);
            end
            if (c == 2) begin
                instr_valid = 1'b0;
                alu_carry   = v.carry;
                alu_zero    = v.zero;
                if ((v.mask & M_OP)  != 0) compare("alu_op", alu_op, v.op);
                if ((v.mask & M_IMM) != 0) compare("imm", imm, v.imm);
                if ((v.mask & M_SRC) != 0) compare("alu_src_imm", alu_src_imm, v.src);
                if ((v.mask & M_RS1) != 0) compare("rs1", rs1, v.rs1);
                if ((v.mask & M_RS2) != 0) compare("rs2", rs2, v.rs2);
            end
            if (c == 3) begin
                alu_carry = ~v.carry;
                alu_zero  = ~v.zero;
            end
            if (mem_re && mre_seen == 0) mre_seen = c;
            if (mem_we && mwe_seen == 0) mwe_seen = c;
            if (done || illegal) begin
                ended = 1'b1;
                checkOutput(c, mre_seen, mwe_seen);
            end
        end
        if (!ended) begin
            compare("completion_seen", ended, 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            instr_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t v;
        // instr, carry, zero, op, imm, src, rs1, rs2, rd, mask, len, reg_we, pc_sel, mre, mwe
        vecs.push_back(mk(32'h002081B3, 0, 0, 4'h0, 0, 0, 1, 2, 3, M_OP|M_SRC|M_RS1|M_RS2|M_RD, 3, 1, 0, 0, 0));
        vecs.push_back(mk(32'h402081B3, 0, 0, 4'h1, 0, 0, 1, 2, 3, M_OP|M_SRC|M_RS1|M_RS2|M_RD, 3, 1, 0, 0, 0));
        vecs.push_back(mk(32'h4020D1B3, 0, 0, 4'h5, 0, 0, 1, 2, 3, M_OP|M_SRC|M_RS1|M_RS2|M_RD, 3, 1, 0, 0, 0));
        vecs.push_back(mk(32'h0020C1B3, 0, 0, 4'h3, 0, 0, 1, 2, 3, M_OP|M_SRC|M_RS1|M_RS2|M_RD, 3, 1, 0, 0, 0));
        vecs.push_back(mk(32'h0080A283, 0, 0, 4'h0, 8, 1, 1, 0, 5, M_OP|M_IMM|M_SRC|M_RS1|M_RD, 4, 1, 0, 3, 0));
        vecs.push_back(mk(32'h0020A623, 0, 0, 4'h0, 12, 1, 1, 2, 0, M_OP|M_IMM|M_SRC|M_RS1|M_RS2, 4, 0, 0, 0, 3));
        vecs.push_back(mk(32'h00208463, 1, 0, 4'hA, 8, 0, 1, 2, 0, M_OP|M_IMM|M_SRC|M_RS1|M_RS2, 3, 0, 1, 0, 0));
        vecs.push_back(mk(32'h00208463, 0, 1, 4'hA, 8, 0, 1, 2, 0, M_OP|M_IMM|M_SRC|M_RS1|M_RS2, 3, 0, 0, 0, 0));
        vecs.push_back(mk(32'h00209463, 0, 1, 4'h9, 8, 0, 1, 2, 0, M_OP|M_IMM|M_SRC|M_RS1|M_RS2, 3, 0, 1, 0, 0));
        vecs.push_back(mk(32'h00209463, 1, 0, 4'h9, 8, 0, 1, 2, 0, M_OP|M_IMM|M_SRC|M_RS1|M_RS2, 3, 0, 0, 0, 0));
        vecs.push_back(mk(32'h123453B7, 0, 0, 4'hB, 32'h00012345, 1, 0, 0, 7, M_OP|M_IMM|M_SRC|M_RD, 3, 1, 0, 0, 0));
        vecs.push_back(mk(32'hFFF08213, 0, 0, 4'h0, 32'hFFFFFFFF, 1, 1, 0, 4, M_OP|M_IMM|M_SRC|M_RS1|M_RD, 3, 1, 0, 0, 0));
        vecs.push_back(mk(32'h4030D213, 0, 0, 4'h5, 3, 1, 1, 0, 4, M_OP|M_IMM|M_SRC|M_RS1|M_RD, 3, 1, 0, 0, 0));
        vecs.push_back(mk(32'hFFE0B213, 0, 0, 4'h8, 32'hFFFFFFFE, 1, 1, 0, 4, M_OP|M_IMM|M_SRC|M_RS1|M_RD, 3, 1, 0, 0, 0));
        vecs.push_back(mk(32'h01F09213, 0, 0, 4'h2, 31, 1, 1, 0, 4, M_OP|M_IMM|M_SRC|M_RS1|M_RD, 3, 1, 0, 0, 0));
        vecs.push_back(mkIllegal(32'hFFFFFFFF));
        vecs.push_back(mkIllegal(32'h0020A1B3));

        rst_n       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        alu_zero    = 1'b0;
        alu_carry   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare("reset_outputs", allOuts(), 64'h0);
        rst_n = 1'b1;
        #1;
        compare("ready_after_reset", instr_ready, 1);
        compare("no_strobe_after_reset", {pc_we, reg_we, done}, 3'b0);

        foreach (vecs[i]) runVector(vecs[i]);

        // Reset asserted in EXEC must abandon the instruction silently.
        v = vecs[0];
        instr       = v.instr;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compare("reset_mid_outputs", allOuts(), 64'h0);
        @(negedge clk);
        compare("reset_held_outputs", allOuts(), 64'h0);
        rst_n = 1'b1;
        #1;
        compare("ready_after_mid_reset", instr_ready, 1);
        compare("no_strobe_mid_reset", {pc_we, reg_we, done, mem_re, mem_we}, 5'b0);
        @(negedge clk);
        compare("idle_stays_quiet", {pc_we, reg_we, done, instr_ready}, 4'b0001);
        runVector(vecs[4]);
        runVector(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
